// File: rtl/weight_load_ctrl.sv
// Weight tile loader: pops one tile per step from the weight FIFO, streams its
// rows (highest index first) into the PE array, then holds until compute completes.
module weight_load_ctrl #(
  parameter int WEIGHT_BW   = 8,
  parameter int NUM_PE_ROWS = 8,
  parameter int MATRIX_SIZE = 8,
  parameter int TILE_CNT_W  = 8,
  localparam int ROW_W  = WEIGHT_BW * MATRIX_SIZE,
  localparam int TILE_W = ROW_W * NUM_PE_ROWS,
  localparam int IDX_W  = (NUM_PE_ROWS > 1) ? $clog2(NUM_PE_ROWS) : 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic                  abort,
  input  logic [TILE_CNT_W-1:0] num_tiles,
  input  logic                  fifo_empty,
  input  logic [TILE_W-1:0]     fifo_data,
  output logic                  fifo_rd_en,
  output logic                  w_row_valid,
  output logic [IDX_W-1:0]      w_row_idx,
  output logic [ROW_W-1:0]      w_row_data,
  input  logic                  compute_done,
  output logic                  tile_ready,
  output logic [TILE_CNT_W-1:0] tile_idx,
  output logic                  busy,
  output logic                  starve,
  output logic                  done,
  output logic [2:0]            dbg_state
);

  typedef enum logic [2:0] {
    S_IDLE      = 3'd0,
    S_WAIT_FIFO = 3'd1,
    S_LOAD      = 3'd2,
    S_COMPUTE   = 3'd3,
    S_DONE      = 3'd4
  } state_e;

  localparam logic [IDX_W-1:0] LAST_ROW = IDX_W'(NUM_PE_ROWS - 1);

  state_e                state_q, state_d;
  logic [IDX_W-1:0]      row_q, row_d;
  logic [TILE_CNT_W-1:0] tile_idx_q, tile_idx_d;
  logic [TILE_CNT_W-1:0] ntiles_q, ntiles_d;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= S_IDLE;
      row_q      <= '0;
      tile_idx_q <= '0;
      ntiles_q   <= '0;
    end else begin
      state_q    <= state_d;
      row_q      <= row_d;
      tile_idx_q <= tile_idx_d;
      ntiles_q   <= ntiles_d;
    end
  end

  // Handshakes: fifo_rd_en pops the FIFO on the edge it is high (data_out is valid
  // from the next cycle); w_row_valid/compute_done are one-way strobes, no backpressure.
  always_comb begin
    state_d     = state_q;
    row_d       = row_q;
    tile_idx_d  = tile_idx_q;
    ntiles_d    = ntiles_q;
    fifo_rd_en  = 1'b0;
    w_row_valid = 1'b0;
    w_row_idx   = '0;
    w_row_data  = '0;
    tile_ready  = 1'b0;
    starve      = 1'b0;
    done        = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        if (start && !abort) begin
          ntiles_d   = num_tiles;
          tile_idx_d = '0;
          state_d    = (num_tiles == '0) ? S_DONE : S_WAIT_FIFO;
        end
      end
      S_WAIT_FIFO: begin
        starve = fifo_empty;
        if (abort) begin
          state_d = S_IDLE;
        end else if (!fifo_empty) begin
          fifo_rd_en = 1'b1;
          row_d      = LAST_ROW;
          state_d    = S_LOAD;
        end
      end
      S_LOAD: begin
        w_row_valid = 1'b1;
        w_row_idx   = row_q;
        w_row_data  = fifo_data[row_q * ROW_W +: ROW_W];
        if (abort) begin
          state_d = S_IDLE;
        end else if (row_q == '0) begin
          state_d = S_COMPUTE;
        end else begin
          row_d = row_q - IDX_W'(1);
        end
      end
      S_COMPUTE: begin
        tile_ready = 1'b1;
        if (abort) begin
          state_d = S_IDLE;
        end else if (compute_done) begin
          tile_idx_d = tile_idx_q + TILE_CNT_W'(1);
          state_d    = (tile_idx_d == ntiles_q) ? S_DONE : S_WAIT_FIFO;
        end
      end
      S_DONE: begin
        done    = !abort;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  assign tile_idx  = tile_idx_q;
  assign busy      = (state_q != S_IDLE);
  assign dbg_state = state_q;

endmodule

// File: tb/tb_weight_load_ctrl.sv
// Bench for weight_load_ctrl: FIFO model, timed expectation queues filled by the
// driver, and a negedge monitor that pops and compares whatever the DUT presents.
module tb_weight_load_ctrl;
  localparam int WB  = 8;
  localparam int NR  = 8;
  localparam int MS  = 8;
  localparam int TW  = 8;
  localparam int RW  = WB * MS;
  localparam int TBW = RW * NR;
  localparam int IW  = $clog2(NR);
  localparam int VW  = 2 + IW + RW + 1 + TW + 3;
  localparam int FD  = 512;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic start = 1'b0, abort = 1'b0, compute_done = 1'b0;
  logic [TW-1:0] num_tiles = '0;
  logic fifo_empty;
  logic [TBW-1:0] fifo_data = '0;
  logic fifo_rd_en, w_row_valid, tile_ready, busy, starve, done;
  logic [IW-1:0] w_row_idx;
  logic [RW-1:0] w_row_data;
  logic [TW-1:0] tile_idx;
  logic [2:0] dbg_state;

  weight_load_ctrl #(.WEIGHT_BW(WB), .NUM_PE_ROWS(NR), .MATRIX_SIZE(MS), .TILE_CNT_W(TW)) dut (
    .clk(clk), .rst(rst), .start(start), .abort(abort), .num_tiles(num_tiles),
    .fifo_empty(fifo_empty), .fifo_data(fifo_data), .fifo_rd_en(fifo_rd_en),
    .w_row_valid(w_row_valid), .w_row_idx(w_row_idx), .w_row_data(w_row_data),
    .compute_done(compute_done), .tile_ready(tile_ready), .tile_idx(tile_idx),
    .busy(busy), .starve(starve), .done(done), .dbg_state(dbg_state)
  );

  always #5 clk = ~clk;

  // ---------------- weight FIFO model (registered data_out) ----------------
  logic [TBW-1:0] fifo_mem [FD];
  int wr_ptr = 0;
  int rd_ptr = 0;
  assign fifo_empty = (wr_ptr == rd_ptr);

  always @(posedge clk) begin
    if (fifo_rd_en && !fifo_empty) begin
      fifo_data <= fifo_mem[rd_ptr % FD];
      rd_ptr    <= rd_ptr + 1;
    end
  end

  // ---------------- scoreboard state ----------------
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic [IW+RW-1:0] exp_row_q[$];
  int               exp_row_cyc_q[$];
  int               exp_rd_q[$];
  int               exp_tr_q[$];
  logic [TW-1:0]    exp_done_q[$];
  int               exp_done_cyc_q[$];
  logic [VW-1:0]    exp_snap_q[$];
  int               exp_snap_cyc_q[$];
  int  tmo_cnt = 0;
  logic end_req = 1'b0;
  int checks = 0;
  int errors = 0;

  function automatic logic [VW-1:0] idle_vec(input logic [TW-1:0] t);
    idle_vec = {{(VW-TW-3){1'b0}}, t, 3'b000};
  endfunction

  function automatic logic [VW-1:0] starve_vec(input logic [TW-1:0] t);
    starve_vec = {{(VW-TW-3){1'b0}}, t, 3'b110};
  endfunction

  // ---------------- monitor ----------------
  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s @cyc %0d: got %0h expected %0h", name, cyc, act, exp);
    end
  endtask

  logic tr_prev = 1'b0;
  logic [VW-1:0] act_vec;

  always @(negedge clk) begin
    act_vec = {fifo_rd_en, w_row_valid, w_row_idx, w_row_data, tile_ready, tile_idx, busy, starve, done};
    if (w_row_valid) begin
      if (exp_row_q.size() == 0) check("row_unexpected", w_row_valid, 0);
      else begin
        check("row_value", {w_row_idx, w_row_data}, exp_row_q.pop_front());
        check("row_cycle", cyc, exp_row_cyc_q.pop_front());
      end
    end
    if (fifo_rd_en) begin
      check("rd_while_empty", fifo_empty, 0);
      if (exp_rd_q.size() == 0) check("rd_unexpected", fifo_rd_en, 0);
      else check("rd_cycle", cyc, exp_rd_q.pop_front());
    end
    if (tile_ready && !tr_prev) begin
      if (exp_tr_q.size() == 0) check("ready_unexpected", tile_ready, 0);
      else check("ready_cycle", cyc, exp_tr_q.pop_front());
    end
    tr_prev = tile_ready;
    if (done) begin
      if (exp_done_q.size() == 0) check("done_unexpected", done, 0);
      else begin
        check("done_tile_idx", tile_idx, exp_done_q.pop_front());
        check("done_cycle", cyc, exp_done_cyc_q.pop_front());
      end
    end
    while (exp_snap_q.size() > 0 && exp_snap_cyc_q[0] <= cyc) begin
      if (exp_snap_cyc_q[0] == cyc) check("outputs_snapshot", act_vec, exp_snap_q[0]);
      else check("snapshot_missed", cyc, exp_snap_cyc_q[0]);
      void'(exp_snap_q.pop_front());
      void'(exp_snap_cyc_q.pop_front());
    end
    if (end_req || cyc > 60000) begin
      check("watchdog", cyc > 60000, 0);
      check("rows_left", exp_row_q.size(), 0);
      check("pops_left", exp_rd_q.size(), 0);
      check("ready_left", exp_tr_q.size(), 0);
      check("done_left", exp_done_q.size(), 0);
      check("snaps_left", exp_snap_q.size(), 0);
      check("wait_timeouts", tmo_cnt, 0);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
    end
  end

  // ---------------- driver tasks ----------------
  task automatic push_tile(input logic [TBW-1:0] t);
    fifo_mem[wr_ptr % FD] = t;
    wr_ptr = wr_ptr + 1;
  endtask

  function automatic logic [TBW-1:0] rand_tile();
    for (int i = 0; i < TBW / 32; i++) rand_tile[i*32 +: 32] = $urandom;
  endfunction

  // A popped tile shows up as rows NR-1..0 on consecutive cycles after the pop.
  task automatic expect_rows(input logic [TBW-1:0] t, input int rdc, input int nrows, input bit with_ready);
    exp_rd_q.push_back(rdc);
    for (int k = 0; k < nrows; k++) begin
      int r = NR - 1 - k;
      exp_row_q.push_back({IW'(r), t[r*RW +: RW]});
      exp_row_cyc_q.push_back(rdc + 1 + k);
    end
    if (with_ready) exp_tr_q.push_back(rdc + NR + 1);
  endtask

  task automatic expect_done(input logic [TW-1:0] t, input int c);
    exp_done_q.push_back(t);
    exp_done_cyc_q.push_back(c);
  endtask

  task automatic expect_snap(input logic [VW-1:0] v, input int c);
    exp_snap_q.push_back(v);
    exp_snap_cyc_q.push_back(c);
  endtask

  task automatic start_job(input logic [TW-1:0] n, output int base);
    @(negedge clk);
    base = cyc;
    num_tiles = n;
    start = 1'b1;
  endtask

  task automatic pulse_done(output int c);
    @(negedge clk);
    c = cyc;
    compute_done = 1'b1;
  endtask

  task automatic tick_clear();
    @(negedge clk);
    start = 1'b0;
    abort = 1'b0;
    compute_done = 1'b0;
  endtask

  task automatic wait_ready();
    int n = 0;
    while (!tile_ready && n < 60) begin
      @(negedge clk);
      n++;
    end
    if (!tile_ready) tmo_cnt++;
  endtask

  task automatic run_job(input int n, input bit use_first, input logic [TBW-1:0] first);
    logic [TBW-1:0] t[$];
    int base, c;
    c = 0;
    for (int i = 0; i < n; i++) begin
      t.push_back((i == 0 && use_first) ? first : rand_tile());
      push_tile(t[i]);
    end
    start_job(TW'(n), base);
    expect_rows(t[0], base + 1, NR, 1'b1);
    tick_clear();
    for (int i = 0; i < n; i++) begin
      wait_ready();
      repeat ($urandom_range(0, 2)) @(negedge clk);
      pulse_done(c);
      if (i < n - 1) expect_rows(t[i+1], c + 1, NR, 1'b1);
      else expect_done(TW'(n), c + 1);
      tick_clear();
    end
    expect_snap(idle_vec(TW'(n)), c + 2);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    logic [TBW-1:0] t1, ta, tb, tc, td, te, tg, th;
    int base, c, c3;

    @(negedge clk);
    expect_snap(idle_vec('0), cyc + 1);
    repeat (2) @(negedge clk);
    rst = 1'b0;

    // single tile, row r holds r+1 in every weight
    for (int r = 0; r < NR; r++)
      for (int k = 0; k < MS; k++) t1[r*RW + k*WB +: WB] = WB'(r + 1);
    run_job(1, 1'b1, t1);

    // abort together with start in IDLE: nothing starts, tile_idx kept
    @(negedge clk);
    c = cyc;
    start = 1'b1; abort = 1'b1; num_tiles = 8'd1;
    expect_snap(idle_vec(8'd1), c + 1);
    tick_clear();

    // three tiles with the FIFO running dry before the second
    ta = rand_tile(); tb = rand_tile(); tc = rand_tile();
    push_tile(ta);
    start_job(8'd3, base);
    expect_rows(ta, base + 1, NR, 1'b1);
    tick_clear();
    wait_ready();
    pulse_done(c);
    tick_clear();
    expect_snap(starve_vec(8'd1), c + 2);
    repeat ($urandom_range(1, 4)) @(negedge clk);
    @(posedge clk);
    #1;
    push_tile(tb);
    push_tile(tc);
    c3 = cyc;
    expect_rows(tb, c3, NR, 1'b1);
    @(negedge clk);
    wait_ready();
    pulse_done(c);
    expect_rows(tc, c + 1, NR, 1'b1);
    tick_clear();
    wait_ready();
    pulse_done(c);
    expect_done(8'd3, c + 1);
    tick_clear();
    expect_snap(idle_vec(8'd3), c + 2);

    // zero-tile job with tiles waiting in the FIFO: no pop, immediate done
    td = rand_tile(); te = rand_tile();
    push_tile(td);
    push_tile(te);
    start_job(8'd0, base);
    expect_done(8'd0, base + 1);
    tick_clear();
    expect_snap(idle_vec(8'd0), base + 2);

    // abort while row 4 of the second tile is presented
    start_job(8'd2, base);
    expect_rows(td, base + 1, NR, 1'b1);
    tick_clear();
    wait_ready();
    pulse_done(c);
    expect_rows(te, c + 1, 4, 1'b0);
    tick_clear();
    while (cyc < c + 5) @(negedge clk);
    abort = 1'b1;
    expect_snap(idle_vec(8'd1), c + 6);
    tick_clear();
    repeat (2) @(negedge clk);
    run_job(1, 1'b0, '0);

    // start and compute_done during LOAD are ignored
    tg = rand_tile();
    push_tile(tg);
    start_job(8'd1, base);
    expect_rows(tg, base + 1, NR, 1'b1);
    tick_clear();
    while (cyc < base + 3) @(negedge clk);
    start = 1'b1; num_tiles = 8'd5; compute_done = 1'b1;
    tick_clear();
    wait_ready();
    pulse_done(c);
    expect_done(8'd1, c + 1);
    tick_clear();
    expect_snap(idle_vec(8'd1), c + 2);

    // asynchronous reset in the middle of COMPUTE
    th = rand_tile();
    push_tile(th);
    start_job(8'd2, base);
    expect_rows(th, base + 1, NR, 1'b1);
    tick_clear();
    wait_ready();
    repeat ($urandom_range(0, 2)) @(negedge clk);
    @(posedge clk);
    #2;
    rst = 1'b1;
    expect_snap(idle_vec('0), cyc);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    expect_snap(idle_vec('0), cyc + 1);
    expect_snap(idle_vec('0), cyc + 3);
    repeat (4) @(negedge clk);

    // random multi-tile jobs, then the largest tile count
    for (int j = 0; j < 2; j++) run_job($urandom_range(2, 5), 1'b0, '0);
    run_job(255, 1'b0, '0);

    repeat (3) @(negedge clk);
    end_req = 1'b1;
  end

endmodule
